window_filter_proc: RTL and testbench

WINDOW_FILTER_PROC -- requirements
Module: window_filter_proc

---
 rtl/window_filter_proc.sv | 167 ++++++++++++++++
 tb/tb_window_filter_proc.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_filter_proc.sv
// 3x3 window filter over a raster video stream: bypass, median, min (erode) or max (dilate).
// Latency: fixed 4 cycles in every mode; vsync/href are delayed by the same 4 stages.
// Backpressure: none, the pixel clock stream is consumed one pixel per href-high cycle.
module window_filter_proc #(
   parameter logic [10:0] IMG_HDISP = 11'd400,
   parameter logic [10:0] IMG_VDISP = 11'd300,
   parameter int          DW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    filt_mode,
   input  logic          per_img_vsync,
   input  logic          per_img_href,
   input  logic [DW-1:0] per_img_gray,
   output logic          post_img_vsync,
   output logic          post_img_href,
   output logic [DW-1:0] post_img_gray,
   output logic [1:0]    mode_active
);

   localparam int AW = (IMG_HDISP > 11'd1) ? $clog2(IMG_HDISP) : 1;

   function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [DW-1:0] mn(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
      return mx(mn(a, b), mn(mx(a, b), c));
   endfunction

   logic          vsync_d, href_d, armed;
   logic [10:0]   col, row;
   logic          vsync_rise, live, col_ok;
   logic [1:0]    mode_sel;
   logic [AW-1:0] addr;
   logic [DW-1:0] lb1 [0:IMG_HDISP-1];
   logic [DW-1:0] lb2 [0:IMG_HDISP-1];
   logic [DW-1:0] lb1_rd, lb2_rd;

   logic [DW-1:0] win [0:2][0:2];
   logic          s1_vs, s1_hr, s1_mask;
   logic [1:0]    s1_mode;
   logic [DW-1:0] s1_pix;

   logic [DW-1:0] r_max [0:2];
   logic [DW-1:0] r_mid [0:2];
   logic [DW-1:0] r_min [0:2];
   logic          s2_vs, s2_hr, s2_mask;
   logic [1:0]    s2_mode;
   logic [DW-1:0] s2_pix;

   logic [DW-1:0] c_lo, c_mid, c_hi, c_min, c_max;
   logic          s3_vs, s3_hr, s3_mask;
   logic [1:0]    s3_mode;
   logic [DW-1:0] s3_pix;
   logic [DW-1:0] filt_res;

   // A new frame picks up filt_mode in the same cycle its vsync rises.
   assign vsync_rise = per_img_vsync & ~vsync_d;
   assign live       = armed | vsync_rise;
   assign mode_sel   = vsync_rise ? filt_mode : mode_active;
   assign col_ok     = col < IMG_HDISP;
   assign addr       = col_ok ? col[AW-1:0] : '0;
   assign lb1_rd     = lb1[addr];
   assign lb2_rd     = lb2[addr];

   always_ff @(posedge clk) begin
      if (!rst && per_img_href && col_ok) begin
         lb1[addr] <= per_img_gray;
         lb2[addr] <= lb1_rd;
      end
   end

   // vsync_d keeps tracking through reset so a frame already open is not seen as a new one.
   always_ff @(posedge clk) begin
      vsync_d <= per_img_vsync;
      if (rst) begin
         href_d      <= 1'b0;
         armed       <= 1'b0;
         mode_active <= 2'd1;
         col         <= '0;
         row         <= '0;
      end else begin
         href_d <= per_img_href;
         if (vsync_rise) begin
            armed       <= 1'b1;
            mode_active <= filt_mode;
         end
         if (!per_img_href)
            col <= '0;
         else if (col_ok)
            col <= col + 11'd1;
         if (!per_img_vsync)
            row <= '0;
         else if (href_d && !per_img_href && row < IMG_VDISP)
            row <= row + 11'd1;
      end
   end

   always_comb begin
      case (s3_mode)
         2'd1:    filt_res = med3(c_lo, c_mid, c_hi);
         2'd2:    filt_res = c_min;
         default: filt_res = c_max;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) win[r][c] <= '0;
            r_max[r] <= '0;
            r_mid[r] <= '0;
            r_min[r] <= '0;
         end
         {s1_vs, s1_hr, s1_mask, s1_mode, s1_pix} <= '0;
         {s2_vs, s2_hr, s2_mask, s2_mode, s2_pix} <= '0;
         {s3_vs, s3_hr, s3_mask, s3_mode, s3_pix} <= '0;
         {c_lo, c_mid, c_hi, c_min, c_max}        <= '0;
         post_img_vsync <= 1'b0;
         post_img_href  <= 1'b0;
         post_img_gray  <= '0;
      end else begin
         if (per_img_href) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= per_img_gray;
         end
         s1_vs   <= per_img_vsync & live;
         s1_hr   <= per_img_href & live;
         s1_pix  <= per_img_gray;
         s1_mode <= mode_sel;
         s1_mask <= (row < 11'd2) | (col < 11'd2) | ~col_ok;

         for (int r = 0; r < 3; r++) begin
            r_max[r] <= mx(mx(win[r][0], win[r][1]), win[r][2]);
            r_mid[r] <= med3(win[r][0], win[r][1], win[r][2]);
            r_min[r] <= mn(mn(win[r][0], win[r][1]), win[r][2]);
         end
         {s2_vs, s2_hr, s2_mask, s2_mode, s2_pix} <= {s1_vs, s1_hr, s1_mask, s1_mode, s1_pix};

         // Median of 9 = median of (max of row mins, median of row mids, min of row maxes).
         c_lo  <= mx(mx(r_min[0], r_min[1]), r_min[2]);
         c_mid <= med3(r_mid[0], r_mid[1], r_mid[2]);
         c_hi  <= mn(mn(r_max[0], r_max[1]), r_max[2]);
         c_min <= mn(mn(r_min[0], r_min[1]), r_min[2]);
         c_max <= mx(mx(r_max[0], r_max[1]), r_max[2]);
         {s3_vs, s3_hr, s3_mask, s3_mode, s3_pix} <= {s2_vs, s2_hr, s2_mask, s2_mode, s2_pix};

         post_img_vsync <= s3_vs;
         post_img_href  <= s3_hr;
         post_img_gray  <= !s3_hr           ? '0     :
                           (s3_mode == 2'd0) ? s3_pix :
                           s3_mask           ? '0     : filt_res;
      end
   end

endmodule

// File: tb/tb_window_filter_proc.sv
// Randomised and directed frames against a frame-level reference model of the 3x3 window filter.
module tb_window_filter_proc;
   localparam int DW = 10;
   localparam int H  = 16;
   localparam int V  = 6;

   typedef struct packed {
      logic          vs;
      logic          hr;
      logic [DW-1:0] g;
   } px_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    filt_mode;
   logic          per_img_vsync, per_img_href;
   logic [DW-1:0] per_img_gray;
   logic          post_img_vsync, post_img_href;
   logic [DW-1:0] post_img_gray;
   logic [1:0]    mode_active;

   int errors = 0;
   int checks = 0;

   px_t exp_q[$];
   px_t rec_exp[$];
   px_t rec_obs[$];

   // Reference model state: frame/line position, stored previous lines, current-line window columns.
   bit            m_armed = 0, m_prev_href = 0, m_prev_vs = 0;
   int            m_mode = 1, m_line = 0, m_pos = 0;
   logic [DW-1:0] hist1 [H];
   logic [DW-1:0] hist2 [H];
   logic [DW-1:0] cap_t [H];
   logic [DW-1:0] cap_m [H];
   logic [DW-1:0] cap_b [H];

   always #5 clk = ~clk;

   window_filter_proc #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd6), .DW(DW)) dut (
      .clk(clk), .rst(rst), .filt_mode(filt_mode),
      .per_img_vsync(per_img_vsync), .per_img_href(per_img_href), .per_img_gray(per_img_gray),
      .post_img_vsync(post_img_vsync), .post_img_href(post_img_href), .post_img_gray(post_img_gray),
      .mode_active(mode_active)
   );

   function automatic logic [DW-1:0] gen(input int kind, input int r, input int c, input int w);
      case (kind)
         0:       return DW'(r * w + c);
         1:       return (r == 2 && c == 2) ? DW'(255) : DW'(128);
         2:       return (r == 3 && c == 3) ? DW'(144) : DW'(16);
         default: return DW'($urandom);
      endcase
   endfunction

   // One pixel clock: record the output of the entry made 4 cycles ago, drive, predict, advance.
   task automatic cycle(input logic r, input logic vs, input logic hr, input logic [DW-1:0] pix,
                        input logic [1:0] fm);
      px_t e, o;
      int  n, row, col, t;
      int  v[9];
      n = exp_q.size();
      if (n >= 4) begin
         o.vs = post_img_vsync; o.hr = post_img_href; o.g = post_img_gray;
         rec_obs.push_back(o);
         rec_exp.push_back(exp_q[n-4]);
      end
      rst = r; per_img_vsync = vs; per_img_href = hr; per_img_gray = pix; filt_mode = fm;
      e = '0;
      if (r) begin
         for (int k = 1; k <= 3; k++) if (n - k >= 0) exp_q[n-k] = '0;
         m_armed = 0; m_mode = 1; m_line = 0; m_pos = 0; m_prev_href = 0;
      end else begin
         if (vs && !m_prev_vs) begin m_armed = 1; m_mode = int'(fm); end
         row = m_line; col = m_pos;
         if (hr && col < H) begin
            cap_t[col] = hist2[col]; cap_m[col] = hist1[col]; cap_b[col] = pix;
            hist2[col] = hist1[col]; hist1[col] = pix;
         end
         e.vs = m_armed & vs;
         e.hr = m_armed & hr;
         if (e.hr) begin
            if (m_mode == 0) e.g = pix;
            else if (row >= 2 && col >= 2 && col < H) begin
               for (int k = 0; k < 3; k++) begin
                  v[k] = int'(cap_t[col-2+k]); v[3+k] = int'(cap_m[col-2+k]); v[6+k] = int'(cap_b[col-2+k]);
               end
               for (int i = 0; i < 9; i++)
                  for (int j = 0; j < 8 - i; j++)
                     if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
               e.g = (m_mode == 1) ? DW'(v[4]) : (m_mode == 2) ? DW'(v[0]) : DW'(v[8]);
            end
         end
         if (hr) m_pos = (m_pos < H) ? m_pos + 1 : m_pos;
         else m_pos = 0;
         if (!vs) m_line = 0;
         else if (m_prev_href && !hr && m_line < V) m_line++;
         m_prev_href = hr;
      end
      m_prev_vs = vs;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic frame_start(input logic [1:0] fm);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, fm);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, '0, fm);
   endtask

   task automatic send_line(input logic [1:0] fm, input int w, input int r, input int kind);
      for (int c = 0; c < w; c++) cycle(1'b0, 1'b1, 1'b1, gen(kind, r, c, w), fm);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, fm);
   endtask

   task automatic frame_end(input logic [1:0] fm);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, '0, fm);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, '0, fm);
   endtask

   task automatic run_frame(input logic [1:0] fm0, input logic [1:0] fm1, input int w, input int h,
                            input int kind);
      frame_start(fm0);
      for (int r = 0; r < h; r++) send_line((r == 0) ? fm0 : fm1, w, r, kind);
      frame_end(fm1);
   endtask

   task automatic test_reset();
      repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, 2'd0);
      cycle(1'b0, 1'b0, 1'b0, '0, 2'd2);
      checks++; if ({post_img_vsync, post_img_href} !== 2'b00) begin errors++;
         $display("FAIL reset_sync: got vs/hr=%b%b, expected 00", post_img_vsync, post_img_href); end
      checks++; if (post_img_gray !== '0) begin errors++;
         $display("FAIL reset_gray: got %0h, expected 0", post_img_gray); end
      checks++; if (mode_active !== 2'd1) begin errors++;
         $display("FAIL reset_mode: got %0d, expected 1", mode_active); end
   endtask

   task automatic test_bypass();
      int idx = 0;
      rec_obs.delete(); rec_exp.delete();
      run_frame(2'd0, 2'd0, 8, 4, 0);
      foreach (rec_obs[i]) begin
         checks++;
         if (rec_obs[i] !== rec_exp[i]) begin errors++;
            $display("FAIL bypass_stream[%0d]: got %p, expected %p", i, rec_obs[i], rec_exp[i]); end
         if (rec_obs[i].hr) begin
            checks++;
            if (rec_obs[i].g !== DW'(idx)) begin errors++;
               $display("FAIL bypass_ramp[%0d]: got %0d, expected %0d", idx, rec_obs[i].g, idx); end
            idx++;
         end
      end
      checks++; if (idx != 32) begin errors++;
         $display("FAIL bypass_count: got %0d pixels, expected 32", idx); end
   endtask

   task automatic test_median();
      int n80 = 0, other = 0;
      rec_obs.delete(); rec_exp.delete();
      run_frame(2'd1, 2'd1, 8, 5, 1);
      foreach (rec_obs[i]) begin
         checks++;
         if (rec_obs[i] !== rec_exp[i]) begin errors++;
            $display("FAIL median_stream[%0d]: got %p, expected %p", i, rec_obs[i], rec_exp[i]); end
         if (rec_obs[i].hr && rec_obs[i].g === DW'(128)) n80++;
         else if (rec_obs[i].hr && rec_obs[i].g !== '0) other++;
      end
      checks++; if (n80 != 18 || other != 0) begin errors++;
         $display("FAIL median_impulse: got %0d x80 and %0d others, expected 18 and 0", n80, other); end
   endtask

   task automatic test_minmax();
      int n90 = 0, n10 = 0;
      rec_obs.delete(); rec_exp.delete();
      run_frame(2'd3, 2'd3, 8, 6, 2);
      foreach (rec_obs[i]) if (rec_obs[i].hr && rec_obs[i].g === DW'(144)) n90++;
      checks++; if (n90 != 9) begin errors++;
         $display("FAIL max_block: got %0d pixels of x90, expected 9", n90); end
      n90 = 0;
      run_frame(2'd2, 2'd2, 8, 6, 2);
      foreach (rec_obs[i]) begin
         checks++;
         if (rec_obs[i] !== rec_exp[i]) begin errors++;
            $display("FAIL minmax_stream[%0d]: got %p, expected %p", i, rec_obs[i], rec_exp[i]); end
      end
      for (int i = rec_obs.size() - 60; i < rec_obs.size(); i++) begin
         if (rec_obs[i].hr && rec_obs[i].g === DW'(144)) n90++;
         if (rec_obs[i].hr && rec_obs[i].g === DW'(16)) n10++;
      end
      checks++; if (n90 != 0 || n10 != 24) begin errors++;
         $display("FAIL min_interior: got %0d x90 / %0d x10, expected 0 / 24", n90, n10); end
   endtask

   task automatic test_mode_switch();
      rec_obs.delete(); rec_exp.delete();
      run_frame(2'd0, 2'd1, 8, 4, 0);
      checks++; if (mode_active !== 2'd0) begin errors++;
         $display("FAIL switch_hold: got mode_active=%0d, expected 0", mode_active); end
      run_frame(2'd1, 2'd1, 8, 4, 3);
      checks++; if (mode_active !== 2'd1) begin errors++;
         $display("FAIL switch_next: got mode_active=%0d, expected 1", mode_active); end
      foreach (rec_obs[i]) begin
         checks++;
         if (rec_obs[i] !== rec_exp[i]) begin errors++;
            $display("FAIL switch_stream[%0d]: got %p, expected %p", i, rec_obs[i], rec_exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int ridx, hr_seen = 0;
      rec_obs.delete(); rec_exp.delete();
      frame_start(2'd2);
      for (int r = 0; r < 5; r++) send_line(2'd2, 8, r, 3);
      for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1, 1'b1, gen(3, 5, c, 8), 2'd2);
      cycle(1'b1, 1'b1, 1'b1, gen(3, 5, 3, 8), 2'd2);
      ridx = rec_obs.size();
      checks++; if ({post_img_vsync, post_img_href, post_img_gray} !== '0) begin errors++;
         $display("FAIL rst_mid_out: got vs=%b hr=%b gray=%0h, expected all 0",
                  post_img_vsync, post_img_href, post_img_gray); end
      checks++; if (mode_active !== 2'd1) begin errors++;
         $display("FAIL rst_mid_mode: got %0d, expected 1", mode_active); end
      for (int c = 4; c < 8; c++) cycle(1'b0, 1'b1, 1'b1, gen(3, 5, c, 8), 2'd2);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, 2'd2);
      send_line(2'd2, 8, 6, 3);
      send_line(2'd2, 8, 7, 3);
      frame_end(2'd2);
      for (int i = ridx; i < rec_obs.size(); i++) if (rec_obs[i].hr !== 1'b0 || rec_obs[i].vs !== 1'b0) hr_seen++;
      checks++; if (hr_seen != 0) begin errors++;
         $display("FAIL rst_mid_quiet: got %0d active outputs after reset, expected 0", hr_seen); end
      run_frame(2'd3, 2'd3, 8, 4, 3);
      checks++; if (mode_active !== 2'd3) begin errors++;
         $display("FAIL rst_mid_resume: got mode_active=%0d, expected 3", mode_active); end
      foreach (rec_obs[i]) begin
         checks++;
         if (rec_obs[i] !== rec_exp[i]) begin errors++;
            $display("FAIL rst_mid_stream[%0d]: got %p, expected %p", i, rec_obs[i], rec_exp[i]); end
      end
   endtask

   task automatic test_long_line();
      rec_obs.delete(); rec_exp.delete();
      run_frame(2'd1, 2'd1, 20, 4, 3);
      run_frame(2'd1, 2'd1, 16, 4, 3);
      run_frame(2'd0, 2'd0, 20, 3, 3);
      foreach (rec_obs[i]) begin
         checks++;
         if (rec_obs[i] !== rec_exp[i]) begin errors++;
            $display("FAIL long_line_stream[%0d]: got %p, expected %p", i, rec_obs[i], rec_exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      rec_obs.delete(); rec_exp.delete();
      for (int f = 0; f < 8; f++)
         run_frame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(3, 16)), int'($urandom_range(3, 9)), 3);
      foreach (rec_obs[i]) begin
         checks++;
         if (rec_obs[i] !== rec_exp[i]) begin errors++;
            $display("FAIL random_stream[%0d]: got %p, expected %p", i, rec_obs[i], rec_exp[i]); end
      end
   endtask

   initial begin
      rst = 1'b1; filt_mode = 2'd0; per_img_vsync = 1'b0; per_img_href = 1'b0; per_img_gray = '0;
      test_reset();
      test_bypass();
      test_median();
      test_minmax();
      test_mode_switch();
      test_reset_mid();
      test_long_line();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
